avmm_mem_responder: RTL and testbench
=====================================

# avmm_mem_responder

Synthesizable Avalon-MM pipelined slave memory that answers the SDRAM-facing master port of the wordcopy accelerator. It lets benches and on-chip integration run copy engines against a deterministic, configurable memory instead of the real SDRAM controller. The block provides word-addressed storage, configurable fixed read latency and a programmable waitrequest stall pattern. It also carries transaction counters and a sticky protocol-error flag for verification.

## Interface
- ADDR_W, 10, word-address width; depth = 2**ADDR_W 32-bit words
- LATENCY, 2, read latency in cycles, legal 1..4
- STALL_EVERY, 0, 0 = never stall; N>=2 = stall every Nth requesting cycle
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- slave_waitrequest  out  1  request not accepted this cycle
- slave_address  in  32  byte address
- slave_read  in  1  read request
- slave_readdata  out  32  read data, valid with readdatavalid
- slave_readdatavalid  out  1  one-cycle strobe per accepted read
- slave_write  in  1  write request
- slave_writedata  in  32  write data
- rd_count  out  16  accepted reads since reset, wraps
- wr_count  out  16  accepted writes since reset, wraps
- err  out  1  sticky protocol/address error

## Operation
- Accept: a request is accepted at a rising edge where (slave_read|slave_write) && !slave_waitrequest. Master holds address/data/strobes until accepted.
- Word index = slave_address[ADDR_W+1:2].
- Address legality:
  - Illegal if slave_address[1:0] != 0, or any bit [31:ADDR_W+2] is set.
  - Illegal accepted write: dropped, err set.
  - Illegal accepted read: still answered, data 32'h0, err set.
- Read and write both high in the same cycle: treated as a write only (no read response), err set.
- Stall counter scnt (0..STALL_EVERY-1):
  - Increments, mod STALL_EVERY, on every cycle with read|write high.
  - slave_waitrequest = (read|write) && STALL_EVERY!=0 && scnt==STALL_EVERY-1.
  - Combinational from inputs and scnt.
- Reads are pipelined and unlimited outstanding. A new read may be accepted every cycle. Responses return strictly in acceptance order.
- Memory contents are not initialized and not cleared by rst.
- Counters: rd_count/wr_count increment on accepted read/write, wrap at 16'hFFFF to 0.

## Timing
- Reset values (cycle after rst high edge):
  - slave_readdatavalid=0, slave_readdata=0
  - rd_count=0, wr_count=0, err=0, scnt=0
  - slave_waitrequest forced 1 while rst high, otherwise per formula.
- Write accepted at edge k: memory updated at edge k. A read accepted at edge k+1 to the same word returns the new data.
- Read accepted at edge k: readdatavalid high for exactly one cycle, the cycle after edge k+LATENCY-1.
  - LATENCY=1: data valid the cycle immediately after acceptance.
- Back-to-back reads accepted at edges k..k+3 produce valid in 4 consecutive cycles.
- slave_readdata holds its last value when readdatavalid is low.
- Read pipeline: LATENCY-deep shift of {valid, data}. No backpressure on responses.
- Reset mid-operation: all in-flight reads discarded. No readdatavalid after the rst edge until a new read is accepted.
- Stalled cycle: no memory update, no counter update. err is not set by a stall.

## Test plan
- Write 32'hAAAA1110 to 0x100, then read 0x100 (LATENCY=2, STALL_EVERY=0) -> waitrequest never high; readdatavalid exactly 2 cycles after accept; data 32'hAAAA1110; wr_count=1, rd_count=1.
- LATENCY=3: fill words 0x0..0xC with 1..4, then issue 4 back-to-back reads -> 4 consecutive valid cycles carrying 1,2,3,4 in order, first valid 3 cycles after first accept.
- STALL_EVERY=3, read held high for 6 cycles -> waitrequest high on the 3rd and 6th requesting cycles; exactly 4 reads accepted; 4 responses.
- Read 0x102 (misaligned), then write 0x00001000 (out of range for ADDR_W=10) -> read returns 0 with valid; write dropped; err=1 and stays 1.
- Read and write high together at 0x40 with data 0x5A5A5A5A -> no readdatavalid; subsequent read of 0x40 returns 0x5A5A5A5A; err=1.
- Read accepted, rst asserted next cycle -> readdatavalid never asserts for it; counters 0; previously written word still readable after reset.

Source files
------------

// File: rtl/avmm_mem_responder.sv
// Avalon-MM pipelined slave memory with fixed read latency,
// programmable waitrequest stall pattern, counters and error flag.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   slave_waitrequest   : request not accepted this cycle
//   slave_address       : byte address (word index = [ADDR_W+1:2])
//   slave_read/write    : request strobes, held until accepted
//   slave_writedata     : write data
//   slave_readdata      : read data, qualified by readdatavalid
//   slave_readdatavalid : one-cycle strobe per accepted read
//   rd_count, wr_count  : accepted reads / writes, wrapping
//   err                 : sticky protocol / address error
module avmm_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter int STALL_EVERY = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SC_W  =
    (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
  localparam bit STALL_EN = (STALL_EVERY != 0);
  localparam logic [SC_W-1:0] SC_LAST =
    (STALL_EVERY > 0) ? SC_W'(STALL_EVERY - 1) : '0;

  logic [31:0]        r_mem [DEPTH];
  logic [SC_W-1:0]    r_scnt;
  logic [LATENCY-1:0] r_pv;
  logic [31:0]        r_pd [LATENCY];
  logic [15:0]        r_rd_cnt;
  logic [15:0]        r_wr_cnt;
  logic               r_err;

  logic              w_req;
  logic              w_stall;
  logic              w_acc;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_both;
  logic              w_bad_addr;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rdata;

  assign w_req   = slave_read | slave_write;
  assign w_stall = STALL_EN && (r_scnt == SC_LAST);

  // Held high through reset so nothing is accepted while
  // state is being cleared.
  assign slave_waitrequest = rst | (w_req & w_stall);

  assign w_acc    = w_req & ~slave_waitrequest;
  assign w_both   = slave_read & slave_write;
  assign w_wr_acc = w_acc & slave_write;
  // A combined read+write is a write only.
  assign w_rd_acc = w_acc & slave_read & ~slave_write;

  assign w_idx = slave_address[ADDR_W+1:2];
  assign w_bad_addr =
    (slave_address[1:0] != 2'b00) |
    (slave_address[31:ADDR_W+2] != '0);

  assign w_rdata = w_bad_addr ? 32'h0 : r_mem[w_idx];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_bad_addr) begin
      r_mem[w_idx] <= slave_writedata;
    end
  end

  // Response pipeline. Each data stage only loads when the
  // stage behind it is valid, so the last stage keeps the
  // most recent response and readdata holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_pd[0] <= w_rdata;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
        end
      end
    end
  end

  // Stall counter advances on every requesting cycle,
  // including the stalled one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt   <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_req && STALL_EN) begin
        r_scnt <= (r_scnt == SC_LAST) ? '0 : r_scnt + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_wr_acc) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      if (w_acc && (w_bad_addr || w_both)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign slave_readdatavalid = r_pv[LATENCY-1];
  assign slave_readdata      = r_pd[LATENCY-1];
  assign rd_count            = r_rd_cnt;
  assign wr_count            = r_wr_cnt;
  assign err                 = r_err;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Bench for avmm_mem_responder: three instances with
// different latency / stall settings against a cycle model.
module tb_avmm_mem_responder;

  localparam int AW = 10;
  localparam int NI = 3;
  localparam int NS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd  [NI];
  logic        wr  [NI];
  logic [31:0] adr [NI];
  logic [31:0] wd  [NI];
  logic        wq  [NI];
  logic [31:0] rdd [NI];
  logic        rv  [NI];
  logic [15:0] rc  [NI];
  logic [15:0] wc  [NI];
  logic        er  [NI];

  avmm_mem_responder #(
    .ADDR_W(AW), .LATENCY(2), .STALL_EVERY(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(wq[0]),
    .slave_address(adr[0]),
    .slave_read(rd[0]),
    .slave_readdata(rdd[0]),
    .slave_readdatavalid(rv[0]),
    .slave_write(wr[0]),
    .slave_writedata(wd[0]),
    .rd_count(rc[0]), .wr_count(wc[0]), .err(er[0])
  );

  avmm_mem_responder #(
    .ADDR_W(AW), .LATENCY(3), .STALL_EVERY(0)
  ) u1 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(wq[1]),
    .slave_address(adr[1]),
    .slave_read(rd[1]),
    .slave_readdata(rdd[1]),
    .slave_readdatavalid(rv[1]),
    .slave_write(wr[1]),
    .slave_writedata(wd[1]),
    .rd_count(rc[1]), .wr_count(wc[1]), .err(er[1])
  );

  avmm_mem_responder #(
    .ADDR_W(AW), .LATENCY(1), .STALL_EVERY(3)
  ) u2 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(wq[2]),
    .slave_address(adr[2]),
    .slave_read(rd[2]),
    .slave_readdata(rdd[2]),
    .slave_readdatavalid(rv[2]),
    .slave_write(wr[2]),
    .slave_writedata(wd[2]),
    .rd_count(rc[2]), .wr_count(wc[2]), .err(er[2])
  );

  int lat [NI] = '{2, 3, 1};
  int se  [NI] = '{0, 0, 3};

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  // reference model state
  int          rq   [NI];
  logic [31:0] mm   [NI][1 << AW];
  bit          mk   [NI][1 << AW];
  logic [15:0] erc  [NI];
  logic [15:0] ewc  [NI];
  bit          eer  [NI];
  logic [31:0] last [NI];
  bit          lk   [NI];
  bit          sv   [NI][NS];
  bit          sk   [NI][NS];
  logic [31:0] sd   [NI][NS];
  bit          dacc [NI];
  bit          pend [NI];

  task automatic chk(string tag, logic [31:0] o,
                     logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, o, e);
  endtask

  task automatic step();
    bit acc [NI];
    #1;
    for (int i = 0; i < NI; i++) begin
      bit req;
      bit ew;
      req = rd[i] | wr[i];
      ew = rst || (req && se[i] != 0 &&
                   (rq[i] % se[i]) == se[i] - 1);
      chk($sformatf("wait%0d", i), 32'(wq[i]), 32'(ew));
      acc[i]  = req && !ew;
      dacc[i] = req && !wq[i];
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        rq[i] = 0; erc[i] = 0; ewc[i] = 0; eer[i] = 0;
        last[i] = 0; lk[i] = 1;
        for (int s = 0; s < NS; s++) sv[i][s] = 0;
      end else begin
        if (rd[i] | wr[i]) rq[i]++;
        if (acc[i]) begin
          bit ok;
          int w;
          ok = adr[i][1:0] == 0 &&
               (adr[i] >> (AW + 2)) == 0;
          w = int'(adr[i][AW+1:2]);
          if (wr[i]) begin
            ewc[i]++;
            if (ok) begin
              mm[i][w] = wd[i];
              mk[i][w] = 1;
            end
            if (!ok || rd[i]) eer[i] = 1;
          end else begin
            int s;
            erc[i]++;
            if (!ok) eer[i] = 1;
            s = (cyc + lat[i] - 1) % NS;
            sv[i][s] = 1;
            sk[i][s] = ok ? mk[i][w] : 1'b1;
            sd[i][s] = ok ? mm[i][w] : 32'h0;
          end
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int s;
      s = cyc % NS;
      if (sv[i][s]) begin
        chk($sformatf("rv%0d", i), 32'(rv[i]), 32'(1));
        if (sk[i][s]) chk($sformatf("rdata%0d", i),
                          rdd[i], sd[i][s]);
        last[i] = sd[i][s];
        lk[i] = sk[i][s];
        sv[i][s] = 0;
      end else begin
        chk($sformatf("rv%0d", i), 32'(rv[i]), 32'(0));
        if (lk[i]) chk($sformatf("hold%0d", i),
                       rdd[i], last[i]);
      end
      chk($sformatf("rc%0d", i), 32'(rc[i]), 32'(erc[i]));
      chk($sformatf("wc%0d", i), 32'(wc[i]), 32'(ewc[i]));
      chk($sformatf("err%0d", i), 32'(er[i]), 32'(eer[i]));
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic xfer(int i, bit r, bit w,
                      logic [31:0] a, logic [31:0] d);
    bit done;
    done = 0;
    rd[i] = r; wr[i] = w; adr[i] = a; wd[i] = d;
    for (int n = 0; n < 8 && !done; n++) begin
      step();
      done = dacc[i];
    end
    chk($sformatf("accept%0d", i), 32'(done), 32'(1));
    rd[i] = 0; wr[i] = 0;
  endtask

  initial begin
    rst = 1;
    for (int i = 0; i < NI; i++) begin
      rd[i] = 0; wr[i] = 0; adr[i] = 0; wd[i] = 0;
      pend[i] = 0; lk[i] = 0;
    end
    run(2);
    rst = 0;

    // stall pattern: read held for 6 requesting cycles
    rd[2] = 1; adr[2] = 32'h20;
    run(6);
    rd[2] = 0;
    run(2);
    chk("stall_rc", 32'(rc[2]), 32'(4));

    // basic write then read, latency 2
    xfer(0, 0, 1, 32'h100, 32'hAAAA1110);
    xfer(0, 1, 0, 32'h100, 32'h0);
    run(3);
    chk("tp1_wc", 32'(wc[0]), 32'(1));
    chk("tp1_rc", 32'(rc[0]), 32'(1));

    // back-to-back reads, latency 3
    for (int k = 0; k < 4; k++)
      xfer(1, 0, 1, 32'(k * 4), 32'(k + 1));
    for (int k = 0; k < 4; k++)
      xfer(1, 1, 0, 32'(k * 4), 32'h0);
    run(4);

    // write followed immediately by read of same word
    xfer(2, 0, 1, 32'h44, 32'h0BADF00D);
    xfer(2, 1, 0, 32'h44, 32'h0);
    run(2);

    // illegal addresses
    xfer(0, 0, 1, 32'h0, 32'h11111111);
    run(1);
    chk("err_pre", 32'(er[0]), 32'(0));
    xfer(0, 1, 0, 32'h102, 32'h0);
    xfer(0, 0, 1, 32'h1000, 32'hDEADBEEF);
    xfer(0, 1, 0, 32'h0, 32'h0);
    run(4);
    chk("err_sticky", 32'(er[0]), 32'(1));

    // read and write together
    xfer(1, 1, 1, 32'h40, 32'h5A5A5A5A);
    run(4);
    xfer(1, 1, 0, 32'h40, 32'h0);
    run(4);
    chk("rw_err", 32'(er[1]), 32'(1));

    // reset with a read in flight
    xfer(0, 1, 0, 32'h100, 32'h0);
    rst = 1;
    run(2);
    rst = 0;
    run(4);
    chk("rst_rc", 32'(rc[0]), 32'(0));
    xfer(0, 1, 0, 32'h100, 32'h0);
    run(4);

    // randomized traffic on all instances
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NI; i++) begin
        if (!pend[i]) begin
          int op;
          logic [31:0] a;
          op = int'($urandom_range(0, 3));
          a = 32'($urandom_range(0, 15)) << 2;
          if ($urandom_range(0, 15) == 0) a = a | 32'h1;
          if ($urandom_range(0, 15) == 0) a = a | 32'h1000;
          rd[i] = (op == 1 || op == 2);
          wr[i] = (op == 3);
          if ($urandom_range(0, 31) == 0) begin
            rd[i] = 1; wr[i] = 1;
          end
          adr[i] = a;
          wd[i] = $urandom;
          pend[i] = rd[i] | wr[i];
        end
      end
      step();
      for (int i = 0; i < NI; i++) begin
        if (dacc[i]) begin
          pend[i] = 0;
          rd[i] = 0; wr[i] = 0;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      rd[i] = 0; wr[i] = 0;
    end
    run(6);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
